// File: rtl/icache_refill.sv
// icache_refill: on an ICache miss, reads one aligned BLOCK_SIZE-byte line from a byte-wide RAM
// through the arbiter and presents it little-endian with a single-cycle memDataValid pulse.
module icache_refill #(
  parameter int BLOCK_WIDTH = 4,
  localparam int BLOCK_SIZE = 2**BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    rdyIn,
  input  logic                    missIn,
  input  logic [31:0]             instrAddrIn,
  output logic                    ramReqOut,
  input  logic                    ramGrantIn,
  output logic [31:0]             ramAddrOut,
  input  logic [7:0]              ramDataIn,
  output logic                    memDataValid,
  output logic [31-BLOCK_WIDTH:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut
);
  typedef enum logic [1:0] {IDLE, REQ, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [31-BLOCK_WIDTH:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic [BLOCK_WIDTH:0] issue_q, issue_d, recv_q, recv_d;
  logic pending_q, pending_d;
  logic [BLOCK_SIZE*8-1:0] line_q, line_d, mem_data_q, mem_data_d;
  logic unused_low_addr;
  assign unused_low_addr = ^instrAddrIn[BLOCK_WIDTH-1:0];
  always_ff @(posedge clkIn or negedge resetIn)
    if (!resetIn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      pending_q  <= 1'b0;
      line_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      pending_q  <= pending_d;
      line_q     <= line_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    pending_d  = pending_q;
    line_d     = line_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (rdyIn)
      case (state_q)
        IDLE: if (missIn) begin
          base_d  = instrAddrIn[31:BLOCK_WIDTH];
          state_d = REQ;
        end
        REQ: if (ramGrantIn) begin
          issue_d   = '0;
          recv_d    = '0;
          pending_d = 1'b0;
          state_d   = READ;
        end
        READ: begin
          // A byte whose address went out last cycle arrives now, even if the grant has since dropped
          pending_d = !issue_q[BLOCK_WIDTH] && ramGrantIn;
          issue_d   = pending_d ? issue_q + 1'b1 : issue_q;
          if (pending_q) begin
            line_d[{recv_q[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
            recv_d = recv_q + 1'b1;
          end
          if (recv_d[BLOCK_WIDTH]) begin
            mem_addr_d = base_q;
            mem_data_d = line_d;
            state_d    = DONE;
          end
        end
        DONE: state_d = IDLE;
      endcase
  end
  assign ramReqOut    = state_q == REQ || state_q == READ;
  assign ramAddrOut   = state_q == READ ? {base_q, issue_q[BLOCK_WIDTH-1:0]} : '0;
  assign memDataValid = state_q == DONE;
  assign memAddr      = mem_addr_q;
  assign memDataOut   = mem_data_q;
endmodule
